// File: rtl/rrg_param_loader.sv
// rrg_param_loader: replays four shadowed 64-bit parameters onto the ramp generator registers, then commits.
// Optional: define RRG_LOADER_SKIP_UNCHANGED_EN to skip parameters equal to the last committed set.
module rrg_param_loader #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        host_we,
    input  logic [1:0]  host_sel,
    input  logic [1:0]  host_word,
    input  logic [15:0] host_wdata,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        start_err,
    output logic [15:0] reg_control,
    output logic [15:0] reg_0,
    output logic [15:0] reg_1,
    output logic [15:0] reg_2,
    output logic [15:0] reg_3
);
    localparam int            CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);

    typedef enum logic [2:0] {IDLE, SETUP, HOLD, CSETUP, COMMIT, DONE} state_t;
    state_t state, state_nxt;

    logic [3:0][15:0] shadow  [4];
    logic [63:0]      staging [4];
    logic [63:0]      src     [4];
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
    logic [63:0]      last_committed [4];
`endif
    logic [1:0]       p, p_nxt;
    logic [CW-1:0]    hold_cnt;
    logic [3:0]       send;
    logic             have_first, have_next;
    logic [1:0]       first_idx, next_idx;
    logic             busy_state, abort_ok, hold_last, idle_like;
    logic [15:0]      control_d;
    logic [63:0]      data_d;
    logic             busy_d, done_d, aborted_d, start_err_d;

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign busy_state = (state == SETUP) || (state == HOLD) || (state == CSETUP) || (state == COMMIT);
    assign abort_ok   = abort && busy_state;
    assign hold_last  = (hold_cnt == CW'(1));

    // Before a start is accepted the staging copy is not yet loaded, so parameter selection looks at shadow.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src[i] = idle_like ? 64'(shadow[i]) : staging[i];
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
            send[i] = (src[i] != last_committed[i]);
`else
            send[i] = 1'b1;
`endif
        end
    end

    always_comb begin
        have_first = 1'b0;
        first_idx  = 2'd0;
        have_next  = 1'b0;
        next_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (send[i]) begin
                have_first = 1'b1;
                first_idx  = 2'(i);
            end
            if (send[i] && (i > int'(p))) begin
                have_next = 1'b1;
                next_idx  = 2'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (have_first) begin
                        state_nxt = SETUP;
                        p_nxt     = first_idx;
                    end else begin
                        state_nxt = CSETUP;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP:  state_nxt = HOLD;
            HOLD: begin
                if (hold_last) begin
                    if (have_next) begin
                        state_nxt = SETUP;
                        p_nxt     = next_idx;
                    end else begin
                        state_nxt = CSETUP;
                    end
                end
            end
            CSETUP: state_nxt = COMMIT;
            COMMIT: if (hold_last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (abort_ok) state_nxt = IDLE;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        control_d = 16'd0;
        if (state_nxt == HOLD) control_d = 16'(p_nxt) + 16'd1;
        else if (state_nxt == COMMIT) control_d = 16'd5;
        busy_d      = (state_nxt == SETUP) || (state_nxt == HOLD) ||
                      (state_nxt == CSETUP) || (state_nxt == COMMIT);
        done_d      = (state_nxt == DONE);
        aborted_d   = abort_ok;
        start_err_d = start && busy_state && !abort;
        data_d      = {reg_3, reg_2, reg_1, reg_0};
        if (state_nxt == SETUP) data_d = src[p_nxt];
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            p        <= 2'd0;
            hold_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow[i]  <= '0;
                staging[i] <= '0;
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
                last_committed[i] <= '0;
`endif
            end
        end else begin
            state <= state_nxt;
            p     <= p_nxt;
            if (host_we) shadow[host_sel][host_word] <= host_wdata;
            if (idle_like && start) begin
                for (int i = 0; i < 4; i++) staging[i] <= 64'(shadow[i]);
            end
            if ((state_nxt == HOLD && state != HOLD) || (state_nxt == COMMIT && state != COMMIT))
                hold_cnt <= HOLD_LOAD;
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - CW'(1);
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
            if (state_nxt == DONE && state != DONE) begin
                for (int i = 0; i < 4; i++) last_committed[i] <= staging[i];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            start_err   <= 1'b0;
            reg_control <= 16'd0;
            {reg_3, reg_2, reg_1, reg_0} <= 64'd0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            aborted     <= aborted_d;
            start_err   <= start_err_d;
            reg_control <= control_d;
            {reg_3, reg_2, reg_1, reg_0} <= data_d;
        end
    end
endmodule

// File: tb/tb_rrg_param_loader.sv
// Testbench for rrg_param_loader: transaction-level expected-trace model plus directed and random stimulus.
module tb_rrg_param_loader;
    localparam int HOLD = 16;
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int ERR_AT = SKIP ? 10 : 40;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        host_we = 1'b0;
    logic [1:0]  host_sel = 2'd0;
    logic [1:0]  host_word = 2'd0;
    logic [15:0] host_wdata = 16'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, aborted, start_err;
    logic [15:0] reg_control, reg_0, reg_1, reg_2, reg_3;

    always #5 clk = ~clk;

    rrg_param_loader #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .nReset(nReset), .host_we(host_we), .host_sel(host_sel),
        .host_word(host_word), .host_wdata(host_wdata), .start(start), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .start_err(start_err),
        .reg_control(reg_control), .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3)
    );

    typedef struct {
        logic [15:0] ctrl;
        logic        busy;
        logic        done;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    logic [63:0] m_shadow [4];
    logic [63:0] m_lc [4];
    logic [63:0] m_pending [4];
    logic [15:0] e_ctrl = 16'd0;
    logic        e_busy = 1'b0, e_done = 1'b0, e_aborted = 1'b0, e_err = 1'b0;
    logic [63:0] e_data = 64'd0;
    int checks = 0;
    int fails = 0;
    int cycle = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic checkOutput();
        chk("reg_control", 64'(reg_control), 64'(e_ctrl));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("aborted", 64'(aborted), 64'(e_aborted));
        chk("start_err", 64'(start_err), 64'(e_err));
        chk("data", {reg_3, reg_2, reg_1, reg_0}, e_data);
    endtask

    task automatic modelReset();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 64'd0;
            m_lc[i] = 64'd0;
            m_pending[i] = 64'd0;
        end
        e_ctrl = 16'd0; e_busy = 1'b0; e_done = 1'b0; e_aborted = 1'b0; e_err = 1'b0; e_data = 64'd0;
    endtask

    // Expected per-cycle trace of a whole accepted sequence, built from the snapshot at start time.
    task automatic buildSeq();
        exp_t n;
        logic [63:0] d;
        d = e_data;
        for (int i = 0; i < 4; i++) begin
            m_pending[i] = m_shadow[i];
            if (!SKIP || (m_shadow[i] != m_lc[i])) begin
                d = m_shadow[i];
                n.ctrl = 16'd0; n.busy = 1'b1; n.done = 1'b0; n.data = d;
                q.push_back(n);
                n.ctrl = 16'(i + 1);
                repeat (HOLD) q.push_back(n);
            end
        end
        n.ctrl = 16'd0; n.busy = 1'b1; n.done = 1'b0; n.data = d;
        q.push_back(n);
        n.ctrl = 16'd5;
        repeat (HOLD) q.push_back(n);
        n.ctrl = 16'd0; n.busy = 1'b0; n.done = 1'b1;
        q.push_back(n);
    endtask

    task automatic modelStep(input logic we, input logic [1:0] sel, input logic [1:0] word,
                             input logic [15:0] wd, input logic st, input logic ab);
        exp_t n;
        logic cur_busy;
        cur_busy = e_busy;
        n.ctrl = 16'd0; n.busy = 1'b0; n.done = 1'b0; n.data = e_data;
        e_aborted = 1'b0;
        e_err = st && cur_busy && !ab;
        if (ab && cur_busy) begin
            q.delete();
            e_aborted = 1'b1;
        end else begin
            if (st && !cur_busy) buildSeq();
            if (q.size() > 0) begin
                n = q.pop_front();
                if (n.done) for (int i = 0; i < 4; i++) m_lc[i] = m_pending[i];
            end
        end
        e_ctrl = n.ctrl; e_busy = n.busy; e_done = n.done; e_data = n.data;
        if (we) m_shadow[sel][int'(word)*16 +: 16] = wd;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [1:0] word,
                                 input logic [15:0] wd, input logic st, input logic ab);
        host_we = we; host_sel = sel; host_word = word; host_wdata = wd; start = st; abort = ab;
        modelStep(we, sel, word, wd, st, ab);
        @(posedge clk);
        @(negedge clk);
        cycle++;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic hostWrite(input logic [1:0] sel, input logic [1:0] word, input logic [15:0] wd);
        applyStimulus(1'b1, sel, word, wd, 1'b0, 1'b0);
    endtask

    task automatic waitCtrl(input logic [15:0] code, output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (reg_control == code) begin
                found = 1'b1;
                break;
            end
            idle();
        end
    endtask

    task automatic waitDone(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            idle();
        end
    endtask

    // Issues start, optionally a second start at offset err_at, and measures the done latency.
    task automatic runSeq(input int err_at, output int lat, output int errs, output logic [63:0] code1_data);
        bit seen1;
        lat = -1; errs = 0; code1_data = 64'hDEAD; seen1 = 1'b0;
        applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0);
        for (int i = 1; i < 300; i++) begin
            if (start_err) errs++;
            if (reg_control == 16'd1 && !seen1) begin
                seen1 = 1'b1;
                code1_data = {reg_3, reg_2, reg_1, reg_0};
            end
            if (done) begin
                lat = i;
                break;
            end
            applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, (i == err_at), 1'b0);
        end
    endtask

    initial begin
        int lat, errs;
        logic [63:0] d1;
        bit found, saw5, saw_done;
        logic we, st, ab;
        logic [15:0] wd;

        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        chk("reset_control", 64'(reg_control), 64'd0);
        nReset = 1'b1;

        hostWrite(2'd0, 2'd0, 16'h0004);
        hostWrite(2'd0, 2'd1, 16'h0003);
        hostWrite(2'd0, 2'd2, 16'h0002);
        hostWrite(2'd0, 2'd3, 16'h0001);
        hostWrite(2'd1, 2'd0, 16'h0005);
        hostWrite(2'd2, 2'd0, 16'h0006);
        hostWrite(2'd3, 2'd0, 16'h0007);
        idle();

        runSeq(0, lat, errs, d1);
        chk("first_latency", 64'(lat), 64'd86);
        chk("code1_data", d1, 64'h0001_0002_0003_0004);
        idle();

        runSeq(ERR_AT, lat, errs, d1);
        chk("second_latency", 64'(lat), SKIP ? 64'(HOLD + 2) : 64'd86);
        chk("start_err_pulses", 64'(errs), 64'd1);
        idle();

        for (int s = 0; s < 4; s++) hostWrite(2'(s), 2'd1, 16'h0100 + 16'(s));
        hostWrite(2'd1, 2'd0, 16'h0055);
        applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0);
        waitCtrl(16'd3, found);
        chk("reach_code3", 64'(found), 64'd1);
        repeat (4) idle();
        applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b1);
        chk("abort_pulse", 64'(aborted), 64'd1);
        chk("abort_control", 64'(reg_control), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        saw5 = 1'b0; saw_done = 1'b0;
        for (int i = 0; i < 120; i++) begin
            idle();
            if (reg_control == 16'd5) saw5 = 1'b1;
            if (done) saw_done = 1'b1;
        end
        chk("no_commit_after_abort", 64'(saw5), 64'd0);
        chk("no_done_after_abort", 64'(saw_done), 64'd0);

        applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0);
        waitCtrl(16'd1, found);
        chk("reach_code1", 64'(found), 64'd1);
        hostWrite(2'd1, 2'd0, 16'hAAAA);
        waitCtrl(16'd2, found);
        chk("old_rset", 64'(reg_0), 64'h0055);
        waitDone(found);
        chk("done_after_write", 64'(found), 64'd1);
        idle();
        applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0);
        waitCtrl(16'd2, found);
        chk("new_rset", 64'(reg_0), 64'hAAAA);
        waitDone(found);
        idle();

        applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0);
        waitCtrl(16'd5, found);
        chk("reach_commit", 64'(found), 64'd1);
        nReset = 1'b0;
        #1;
        chk("rst_control", 64'(reg_control), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", {reg_3, reg_2, reg_1, reg_0}, 64'd0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        cycle++;
        checkOutput();
        nReset = 1'b1;
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
        runSeq(0, lat, errs, d1);
        chk("zero_unchanged_latency", 64'(lat), 64'(HOLD + 2));
        for (int s = 0; s < 4; s++) hostWrite(2'(s), 2'd0, 16'h0010 + 16'(s));
        runSeq(0, lat, errs, d1);
        hostWrite(2'd3, 2'd2, 16'h1234);
        runSeq(0, lat, errs, d1);
        chk("one_change_latency", 64'(lat), 64'(2 * (HOLD + 1) + 1));
`else
        applyStimulus(1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0);
        waitCtrl(16'd1, found);
        chk("zero_params", {reg_3, reg_2, reg_1, reg_0}, 64'd0);
        waitDone(found);
        chk("done_after_reset", 64'(found), 64'd1);
`endif
        idle();

        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 39) == 0);
            ab = ($urandom_range(0, 149) == 0);
            if (ab && e_done) st = 1'b0;
            wd = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 2)) : 16'($urandom);
            applyStimulus(we, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), wd, st, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
